// File: rtl/ucode_pkg.sv
// Shared types and defaults for the uCode program RAM arbiter.
package ucode_pkg;

   localparam int unsigned ADDR_SZ_DEF   = 8;
   localparam int unsigned DATA_SZ_DEF   = 16;
   localparam int unsigned BURST_MAX_DEF = 8;
   localparam int unsigned WP_LIMIT_DEF  = 'h80;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_HBURST = 1'b1
   } state_e;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_H = 1'b1
   } port_e;

endpackage

// File: rtl/ucode_rd_tag.sv
// Two-stage {valid, port} shift that follows each granted read through the
// RAM's registered read so the returned word is routed to its requester.
module ucode_rd_tag
   import ucode_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  push_i,
   input  port_e port_i,
   output logic  valid_o,
   output port_e port_o
);

   logic [1:0] valid_q;
   port_e      port0_q;
   port_e      port1_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         port0_q <= PORT_C;
         port1_q <= PORT_C;
      end else begin
         valid_q <= {valid_q[0], push_i};
         port0_q <= port_i;
         port1_q <= port0_q;
      end
   end

   assign valid_o = valid_q[1];
   assign port_o  = port1_q;

endmodule

// File: rtl/ucode_arbiter.sv
// Two-port arbiter (CPU port C, host port H) in front of the uCode program RAM,
// with host burst lock. Optional write protect: UCODE_ARB_WRITE_PROTECT_EN.
module ucode_arbiter
   import ucode_pkg::*;
#(
   parameter int unsigned DATA_SZ   = DATA_SZ_DEF,
   parameter int unsigned ADDR_SZ   = ADDR_SZ_DEF,
   parameter int unsigned BURST_MAX = BURST_MAX_DEF
`ifdef UCODE_ARB_WRITE_PROTECT_EN
   ,
   parameter int unsigned WP_LIMIT  = WP_LIMIT_DEF
`endif
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_c_req,
   input  logic               i_c_wr,
   input  logic [ADDR_SZ-1:0] i_c_addr,
   input  logic [DATA_SZ-1:0] i_c_wdata,
   output logic               o_c_gnt,
   output logic               o_c_rvalid,
   output logic [DATA_SZ-1:0] o_c_rdata,
   input  logic               i_h_req,
   input  logic               i_h_wr,
   input  logic [ADDR_SZ-1:0] i_h_addr,
   input  logic [DATA_SZ-1:0] i_h_wdata,
   output logic               o_h_gnt,
   output logic               o_h_rvalid,
   output logic [DATA_SZ-1:0] o_h_rdata,
   input  logic               i_h_lock,
   output logic               o_mem_wr,
   output logic [ADDR_SZ-1:0] o_mem_waddr,
   output logic [DATA_SZ-1:0] o_mem_wdata,
   output logic [ADDR_SZ-1:0] o_mem_raddr,
   input  logic [DATA_SZ-1:0] i_mem_rdata,
   output logic               o_wp_fault
);

   state_e             state_q, state_d;
   port_e              ptr_q, ptr_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               c_gnt_q, h_gnt_q;
   logic               mem_wr_q, wp_q;
   logic [ADDR_SZ-1:0] waddr_q, raddr_q;
   logic [DATA_SZ-1:0] wdata_q, c_rdata_q, h_rdata_q;
   logic               c_rvalid_q, h_rvalid_q;

   logic               c_elig, h_elig, grant_c, grant_h, grant_any;
   logic               sel_wr, wp_hit, tag_valid;
   logic [ADDR_SZ-1:0] sel_addr;
   logic [DATA_SZ-1:0] sel_wdata;
   port_e              tag_port;

   assign c_elig = i_c_req & ~c_gnt_q;
   assign h_elig = i_h_req & ~h_gnt_q;

   // A burst that ends this edge falls through to normal arbitration in the
   // same edge, with the pointer forced to H so a waiting C wins the tie.
   always_comb begin
      grant_c = 1'b0;
      grant_h = 1'b0;
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (state_q == ST_HBURST && i_h_lock && cnt_q != 8'(BURST_MAX)) begin
         if (h_elig) begin
            grant_h = 1'b1;
            ptr_d   = PORT_H;
            if (c_elig) cnt_d = cnt_q + 8'd1;
         end
      end else begin
         state_d = ST_ARB;
         cnt_d   = '0;
         if (c_elig && h_elig) begin
            grant_c = (state_q == ST_HBURST) || (ptr_q == PORT_H);
            grant_h = ~grant_c;
         end else begin
            grant_c = c_elig;
            grant_h = h_elig;
         end
         if (grant_c) ptr_d = PORT_C;
         if (grant_h) begin
            ptr_d = PORT_H;
            if (i_h_lock) begin
               state_d = ST_HBURST;
               cnt_d   = 8'd1;
            end
         end
      end
   end

   assign grant_any = grant_c | grant_h;
   assign sel_wr    = grant_h ? i_h_wr    : i_c_wr;
   assign sel_addr  = grant_h ? i_h_addr  : i_c_addr;
   assign sel_wdata = grant_h ? i_h_wdata : i_c_wdata;

`ifdef UCODE_ARB_WRITE_PROTECT_EN
   localparam logic [ADDR_SZ-1:0] WP_LIM = ADDR_SZ'(WP_LIMIT);
   assign wp_hit = sel_wr & (sel_addr < WP_LIM);
`else
   assign wp_hit = 1'b0;
`endif

   ucode_rd_tag u_rd_tag (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .push_i  (grant_any & ~sel_wr),
      .port_i  (grant_h ? PORT_H : PORT_C),
      .valid_o (tag_valid),
      .port_o  (tag_port)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_ARB;
         ptr_q      <= PORT_H;
         cnt_q      <= '0;
         c_gnt_q    <= 1'b0;
         h_gnt_q    <= 1'b0;
         mem_wr_q   <= 1'b0;
         wp_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         raddr_q    <= '0;
         c_rvalid_q <= 1'b0;
         h_rvalid_q <= 1'b0;
         c_rdata_q  <= '0;
         h_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         c_gnt_q    <= grant_c;
         h_gnt_q    <= grant_h;
         mem_wr_q   <= grant_any & sel_wr & ~wp_hit;
         wp_q       <= grant_any & wp_hit;
         if (grant_any & sel_wr) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_wdata;
         end
         if (grant_any & ~sel_wr) raddr_q <= sel_addr;
         c_rvalid_q <= tag_valid & (tag_port == PORT_C);
         h_rvalid_q <= tag_valid & (tag_port == PORT_H);
         if (tag_valid && tag_port == PORT_C) c_rdata_q <= i_mem_rdata;
         if (tag_valid && tag_port == PORT_H) h_rdata_q <= i_mem_rdata;
      end
   end

   assign o_c_gnt     = c_gnt_q;
   assign o_h_gnt     = h_gnt_q;
   assign o_c_rvalid  = c_rvalid_q;
   assign o_h_rvalid  = h_rvalid_q;
   assign o_c_rdata   = c_rdata_q;
   assign o_h_rdata   = h_rdata_q;
   assign o_mem_wr    = mem_wr_q;
   assign o_mem_waddr = waddr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_raddr = raddr_q;
   assign o_wp_fault  = wp_q;

endmodule

// File: tb/tb_ucode_arbiter.sv
// Directed self-checking bench for ucode_arbiter with a behavioural RAM whose
// unwritten words read back as their own address.
module tb_ucode_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_c_req, i_c_wr, i_h_req, i_h_wr, i_h_lock;
   logic [7:0]  i_c_addr, i_h_addr;
   logic [15:0] i_c_wdata, i_h_wdata;
   logic        o_c_gnt, o_c_rvalid, o_h_gnt, o_h_rvalid;
   logic [15:0] o_c_rdata, o_h_rdata;
   logic        o_mem_wr, o_wp_fault;
   logic [7:0]  o_mem_waddr, o_mem_raddr;
   logic [15:0] o_mem_wdata;
   logic [15:0] i_mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   ucode_arbiter #(.DATA_SZ(16), .ADDR_SZ(8), .BURST_MAX(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_c_req(i_c_req), .i_c_wr(i_c_wr), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
      .o_c_gnt(o_c_gnt), .o_c_rvalid(o_c_rvalid), .o_c_rdata(o_c_rdata),
      .i_h_req(i_h_req), .i_h_wr(i_h_wr), .i_h_addr(i_h_addr), .i_h_wdata(i_h_wdata),
      .o_h_gnt(o_h_gnt), .o_h_rvalid(o_h_rvalid), .o_h_rdata(o_h_rdata),
      .i_h_lock(i_h_lock),
      .o_mem_wr(o_mem_wr), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
      .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata), .o_wp_fault(o_wp_fault)
   );

   bit [15:0]  mem [256];
   bit [255:0] wr_seen;

   always @(posedge i_clk) begin
      if (o_mem_wr) begin
         mem[o_mem_waddr]     <= o_mem_wdata;
         wr_seen[o_mem_waddr] <= 1'b1;
      end
      i_mem_rdata <= wr_seen[o_mem_raddr] ? mem[o_mem_raddr] : {8'h00, o_mem_raddr};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " c_gnt"}, o_c_gnt, 0);
      chk({tag, " h_gnt"}, o_h_gnt, 0);
      chk({tag, " c_rvalid"}, o_c_rvalid, 0);
      chk({tag, " h_rvalid"}, o_h_rvalid, 0);
      chk({tag, " c_rdata"}, o_c_rdata, 0);
      chk({tag, " h_rdata"}, o_h_rdata, 0);
      chk({tag, " mem_wr"}, o_mem_wr, 0);
      chk({tag, " waddr"}, o_mem_waddr, 0);
      chk({tag, " wdata"}, o_mem_wdata, 0);
      chk({tag, " raddr"}, o_mem_raddr, 0);
      chk({tag, " wp_fault"}, o_wp_fault, 0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_c_req = 0; i_c_wr = 0; i_c_addr = '0; i_c_wdata = '0;
      i_h_req = 0; i_h_wr = 0; i_h_addr = '0; i_h_wdata = '0; i_h_lock = 0;
      #12;
      chk_all_zero("reset");
      step();
      i_rst_n = 1'b1;

      // C single read of 0x80
      i_c_req = 1; i_c_wr = 0; i_c_addr = 8'h80;
      step();
      chk("rd1 c_gnt", o_c_gnt, 1);
      chk("rd1 h_gnt", o_h_gnt, 0);
      chk("rd1 raddr", o_mem_raddr, 8'h80);
      chk("rd1 mem_wr", o_mem_wr, 0);
      i_c_req = 0;
      step();
      chk("rd1 c_gnt off", o_c_gnt, 0);
      chk("rd1 early rvalid", o_c_rvalid, 0);
      i_c_addr = 8'h33;
      step();
      chk("rd1 c_rvalid", o_c_rvalid, 1);
      chk("rd1 c_rdata", o_c_rdata, 16'h0080);
      chk("rd1 h_rvalid", o_h_rvalid, 0);
      chk("rd1 h_rdata", o_h_rdata, 0);
      chk("rd1 raddr hold", o_mem_raddr, 8'h80);
      step();
      chk("rd1 rvalid pulse", o_c_rvalid, 0);
      chk("rd1 rdata hold", o_c_rdata, 16'h0080);

      // Reset again so C wins the first tie, then both read continuously
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
      i_c_req = 1; i_c_wr = 0; i_c_addr = 8'h05;
      i_h_req = 1; i_h_wr = 0; i_h_addr = 8'h06;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("alt c_gnt k%0d", k), o_c_gnt, (k <= 6) && (k % 2 == 1));
         chk($sformatf("alt h_gnt k%0d", k), o_h_gnt, (k <= 6) && (k % 2 == 0));
         chk($sformatf("alt c_rvalid k%0d", k), o_c_rvalid, (k >= 3) && (k % 2 == 1));
         chk($sformatf("alt h_rvalid k%0d", k), o_h_rvalid, (k >= 4) && (k % 2 == 0));
         if (k <= 6)
            chk($sformatf("alt raddr k%0d", k), o_mem_raddr, (k % 2 == 1) ? 8'h05 : 8'h06);
         if (k >= 3 && k % 2 == 1) chk($sformatf("alt c_rdata k%0d", k), o_c_rdata, 16'h0005);
         if (k >= 4 && k % 2 == 0) chk($sformatf("alt h_rdata k%0d", k), o_h_rdata, 16'h0006);
         if (k == 6) begin
            i_c_req = 0;
            i_h_req = 0;
         end
      end

      // H writes BEEF to A0, C reads A0 the very next cycle
      i_h_req = 1; i_h_wr = 1; i_h_addr = 8'hA0; i_h_wdata = 16'hBEEF;
      step();
      chk("wr h_gnt", o_h_gnt, 1);
      chk("wr mem_wr", o_mem_wr, 1);
      chk("wr waddr", o_mem_waddr, 8'hA0);
      chk("wr wdata", o_mem_wdata, 16'hBEEF);
      i_h_req = 0;
      i_c_req = 1; i_c_wr = 0; i_c_addr = 8'hA0;
      step();
      chk("raw c_gnt", o_c_gnt, 1);
      chk("raw mem_wr off", o_mem_wr, 0);
      chk("raw raddr", o_mem_raddr, 8'hA0);
      i_c_req = 0;
      step();
      step();
      chk("raw c_rvalid", o_c_rvalid, 1);
      chk("raw c_rdata", o_c_rdata, 16'hBEEF);

      // Host burst lock with C waiting: 4 H grants, then C, then H unbounded
      i_h_req = 1; i_h_wr = 1; i_h_lock = 1; i_h_addr = 8'hC0; i_h_wdata = 16'h5555;
      i_c_req = 1; i_c_wr = 0; i_c_addr = 8'h07;
      for (int k = 1; k <= 14; k++) begin
         step();
         chk($sformatf("burst h_gnt k%0d", k), o_h_gnt, (k % 2 == 1) && (k != 8));
         chk($sformatf("burst c_gnt k%0d", k), o_c_gnt, k == 8);
         chk($sformatf("burst mem_wr k%0d", k), o_mem_wr, (k % 2 == 1) && (k != 8));
         chk($sformatf("burst c_rvalid k%0d", k), o_c_rvalid, k == 10);
         if (k == 10) chk("burst c_rdata", o_c_rdata, 16'h0007);
         if (k == 8) i_c_req = 0;
      end
      i_h_lock = 0;
      i_h_req  = 0;
      step();
      chk("burst end h_gnt", o_h_gnt, 0);
      step();

      // Write below the protect limit, then read it back
      i_c_req = 1; i_c_wr = 1; i_c_addr = 8'h10; i_c_wdata = 16'h1234;
      step();
      chk("wp c_gnt", o_c_gnt, 1);
`ifdef UCODE_ARB_WRITE_PROTECT_EN
      chk("wp mem_wr", o_mem_wr, 0);
      chk("wp fault", o_wp_fault, 1);
`else
      chk("wp mem_wr", o_mem_wr, 1);
      chk("wp fault", o_wp_fault, 0);
`endif
      i_c_req = 0;
      step();
      chk("wp fault pulse", o_wp_fault, 0);
      i_c_req = 1; i_c_wr = 0;
      step();
      chk("wp rd c_gnt", o_c_gnt, 1);
      i_c_req = 0;
      step();
      step();
      chk("wp rd c_rvalid", o_c_rvalid, 1);
`ifdef UCODE_ARB_WRITE_PROTECT_EN
      chk("wp rd c_rdata", o_c_rdata, 16'h0010);
`else
      chk("wp rd c_rdata", o_c_rdata, 16'h1234);
`endif

      // Asynchronous reset with a read in flight
      i_c_req = 1; i_c_wr = 0; i_c_addr = 8'h20;
      step();
      chk("rst c_gnt", o_c_gnt, 1);
      chk("rst raddr", o_mem_raddr, 8'h20);
      i_c_req = 0;
      i_rst_n = 1'b0;
      #1;
      chk_all_zero("async rst");
      step();
      i_rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("post rst c_rvalid k%0d", k), o_c_rvalid, 0);
         chk($sformatf("post rst h_rvalid k%0d", k), o_h_rvalid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
